// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin front end that hands frames from two requesters
// to a UART transmitter, supervises the transmitter start and enforces an idle
// gap between frames.
module uart_tx_arbiter #(
  parameter int DBITS         = 8,
  parameter int FRAME_SIZE    = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 255,
  localparam int FW           = DBITS * FRAME_SIZE
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          req_a,
  input  logic [FW-1:0] data_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [FW-1:0] data_b,
  output logic          ack_b,
  input  logic          tx_busy,
  output logic          tx_trigger,
  output logic [FW-1:0] tx_in,
  output logic          owner,
  output logic          start_err,
  output logic [7:0]    err_count,
  output logic [1:0]    fsm_state
);

  // Handshake: req_x acts as "valid" and must stay high with data_x stable
  // until ack_x; ack_x is the one-cycle "accepted" pulse, issued only on the
  // capture edge and always together with tx_trigger. Dropping req_x before
  // ack_x withdraws the request silently.

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2,
    GAP        = 2'd3
  } state_t;

  // Counter value on the cycle whose increment would reach the limit.
  localparam logic [15:0] TIMEOUT_LAST = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic        grant;
  logic        pick_b;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        timeout;

  // Next-state decode plus the per-cycle control strobes for the datapath.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    pick_b     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          grant      = 1'b1;
          // On a tie the requester that was not served last wins.
          pick_b     = req_b && (!req_a || !owner);
          cnt_clr    = 1'b1;
          state_next = WAIT_START;
        end
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout    = 1'b1;
          cnt_clr    = 1'b1;
          state_next = GAP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_clr    = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_clr    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Shared counter: start-timeout measure in WAIT_START, gap length in GAP.
  always_ff @(posedge clk_100MHz) begin
    if (!reset || cnt_clr) cnt <= '0;
    else if (cnt_inc)      cnt <= cnt + 16'd1;
  end

  // Frame capture, owner tracking and the one-cycle grant pulses.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      tx_in      <= '0;
      owner      <= 1'b1;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      tx_trigger <= 1'b0;
    end else begin
      ack_a      <= grant && !pick_b;
      ack_b      <= grant && pick_b;
      tx_trigger <= grant;
      if (grant) begin
        tx_in <= pick_b ? data_b : data_a;
        owner <= pick_b;
      end
    end
  end

  // Start-timeout pulse and saturating error counter.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      start_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      start_err <= timeout;
      if (timeout && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized requesters and a behavioural UART, with a
// scoreboard that predicts grant order, frame contents, grant cycles and
// start-timeout pulses from the arbitration and timing rules.
module tb_uart_tx_arbiter;

  localparam int DBITS      = 8;
  localparam int FRAME_SIZE = 4;
  localparam int FW         = DBITS * FRAME_SIZE;
  localparam int G          = 5;
  localparam int TO         = 10;
  localparam int EW         = 1 + FW + 32;
  localparam int NEVER      = 32'h3fff_ffff;

  // ---------------- clock / reset ----------------
  logic clk_100MHz = 1'b0;
  logic reset      = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic          req_a  = 1'b0;
  logic          req_b  = 1'b0;
  logic [FW-1:0] data_a = '0;
  logic [FW-1:0] data_b = '0;
  logic          tx_busy = 1'b0;
  logic          ack_a;
  logic          ack_b;
  logic          tx_trigger;
  logic [FW-1:0] tx_in;
  logic          owner;
  logic          start_err;
  logic [7:0]    err_count;
  logic [1:0]    fsm_state;

  uart_tx_arbiter #(
    .DBITS(DBITS), .FRAME_SIZE(FRAME_SIZE), .GAP_CYCLES(G), .START_TIMEOUT(TO)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .tx_busy(tx_busy), .tx_trigger(tx_trigger), .tx_in(tx_in),
    .owner(owner), .start_err(start_err), .err_count(err_count),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          rst_seen = 1'b0;
  logic [EW-1:0] exp_q[$];        // {who, data, raise cycle}
  int            err_q[$];        // expected start_err cycles
  int            next_ok = 0;     // earliest cycle a grant may appear
  logic          m_owner = 1'b1;
  logic [FW-1:0] m_tx_in = '0;
  int            m_err = 0;
  logic          busy_prev = 1'b0;
  logic          uart_dead = 1'b0;
  int            busy_d = 3;
  int            busy_l = 40;
  logic          sb_owner = 1'b1;

  logic [EW-1:0] e;
  logic          e_who;
  logic [FW-1:0] e_data;
  int            e_raise;
  int            e_cyc;

  always @(posedge clk_100MHz) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk_100MHz) begin
    if (cyc > 0) begin
      if (!rst_seen) begin
        m_tx_in = '0;
        m_owner = 1'b1;
        m_err   = 0;
        err_q.delete();
        check("rst_trigger",   64'(tx_trigger), 64'd0);
        check("rst_ack_a",     64'(ack_a),      64'd0);
        check("rst_ack_b",     64'(ack_b),      64'd0);
        check("rst_start_err", 64'(start_err),  64'd0);
        check("rst_tx_in",     64'(tx_in),      64'd0);
        check("rst_owner",     64'(owner),      64'd1);
        check("rst_err_count", 64'(err_count),  64'd0);
        check("rst_fsm_idle",  64'(fsm_state),  64'd0);
        if (reset) next_ok = cyc + 1;
      end else begin
        check("ack_overlap", 64'(ack_a && ack_b), 64'd0);
        check("trigger_iff_ack", 64'(tx_trigger), 64'(ack_a || ack_b));
        if (tx_trigger || ack_a || ack_b) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant actual=ack_a:%0b,ack_b:%0b required=none cyc=%0d", ack_a, ack_b, cyc);
          end else begin
            e       = exp_q.pop_front();
            e_who   = e[EW-1];
            e_data  = e[EW-2 -: FW];
            e_raise = int'(e[31:0]);
            e_cyc   = (next_ok > e_raise + 1) ? next_ok : e_raise + 1;
            check("grant_ack_a",  64'(ack_a), 64'(!e_who));
            check("grant_ack_b",  64'(ack_b), 64'(e_who));
            check("grant_tx_in",  64'(tx_in), 64'(e_data));
            check("grant_owner",  64'(owner), 64'(e_who));
            check("grant_cycle",  64'(cyc),   64'(e_cyc));
            m_tx_in = e_data;
            m_owner = e_who;
          end
          if (uart_dead) begin
            err_q.push_back(cyc + TO);
            next_ok = cyc + TO + G + 1;
          end else begin
            next_ok = NEVER;
          end
        end else begin
          check("tx_in_hold", 64'(tx_in), 64'(m_tx_in));
          check("owner_hold", 64'(owner), 64'(m_owner));
        end
        if (start_err) begin
          if (err_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start_err actual=1 required=0 cyc=%0d", cyc);
          end else begin
            check("start_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
          end
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end
        check("err_count", 64'(err_count), 64'(m_err));
      end
      // Busy dropped after this cycle's edge: the next edge sees it low.
      if (busy_prev && !tx_busy) next_ok = cyc + 2 + G;
      busy_prev = tx_busy;
    end
  end

  // ---------------- behavioural UART ----------------
  always begin
    @(negedge clk_100MHz);
    if (tx_trigger && !uart_dead && rst_seen) begin
      repeat (busy_d) @(posedge clk_100MHz);
      #1 tx_busy = 1'b1;
      repeat (busy_l) @(posedge clk_100MHz);
      #1 tx_busy = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic raise_req(input logic who, input logic [FW-1:0] d);
    @(posedge clk_100MHz);
    #1;
    if (who) begin data_b = d; req_b = 1'b1; end
    else     begin data_a = d; req_a = 1'b1; end
    exp_q.push_back({who, d, 32'(cyc)});
    sb_owner = who;
  endtask

  task automatic raise_both(input logic [FW-1:0] da, input logic [FW-1:0] db);
    @(posedge clk_100MHz);
    #1;
    data_a = da; data_b = db; req_a = 1'b1; req_b = 1'b1;
    if (sb_owner) begin
      exp_q.push_back({1'b0, da, 32'(cyc)});
      exp_q.push_back({1'b1, db, 32'(cyc)});
    end else begin
      exp_q.push_back({1'b1, db, 32'(cyc)});
      exp_q.push_back({1'b0, da, 32'(cyc)});
    end
  endtask

  task automatic await_ack(input logic who);
    bit got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk_100MHz);
      if (who ? ack_b : ack_a) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_wait_%0d actual=none required=ack cyc=%0d", who, cyc);
    end
  endtask

  task automatic release_req(input logic who);
    @(posedge clk_100MHz);
    #1;
    if (who) req_b = 1'b0;
    else     req_a = 1'b0;
  endtask

  task automatic hold_two(input logic who, input logic [FW-1:0] d1);
    await_ack(who);
    @(posedge clk_100MHz);
    #1;
    if (who) data_b = d1;
    else     data_a = d1;
    await_ack(who);
    release_req(who);
  endtask

  task automatic wait_busy(input logic lvl);
    bit hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk_100MHz);
      if (tx_busy == lvl) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL busy_wait actual=%0b required=%0b cyc=%0d", tx_busy, lvl, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_100MHz);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [FW-1:0] d[4];
    int pat;
    for (int i = 0; i < 4; i++) d[i] = $urandom();

    // Contention held from reset release: A, B, A, B.
    data_a = d[0]; data_b = d[1]; req_a = 1'b1; req_b = 1'b1;
    exp_q.push_back({1'b0, d[0], 32'd0});
    exp_q.push_back({1'b1, d[1], 32'd0});
    exp_q.push_back({1'b0, d[2], 32'd0});
    exp_q.push_back({1'b1, d[3], 32'd0});
    sb_owner = 1'b1;
    wait_cycles(3);
    #1 reset = 1'b1;
    fork
      hold_two(1'b0, d[2]);
      hold_two(1'b1, d[3]);
    join

    // Single request while idle, busy 3 clocks after trigger for 40 clocks.
    wait_cycles(80);
    busy_d = 3; busy_l = 40;
    raise_req(1'b0, 32'h4142_4344);
    await_ack(1'b0);
    release_req(1'b0);

    // Late request during WAIT_DONE; B raised and withdrawn inside GAP.
    wait_busy(1'b1);
    wait_cycles(2);
    raise_req(1'b0, $urandom());
    wait_busy(1'b0);
    @(posedge clk_100MHz);
    #1 data_b = $urandom(); req_b = 1'b1;
    @(posedge clk_100MHz);
    #1 req_b = 1'b0;
    await_ack(1'b0);
    release_req(1'b0);

    // Reset during WAIT_DONE with B pending.
    wait_busy(1'b1);
    wait_cycles(2);
    raise_req(1'b1, $urandom());
    wait_cycles(3);
    #1 reset = 1'b0;
    wait_busy(1'b0);
    wait_cycles(3);
    #1 reset = 1'b1;
    await_ack(1'b1);
    release_req(1'b1);

    // Randomized traffic with a randomly timed UART.
    for (int it = 0; it < 16; it++) begin
      pat = $urandom_range(0, 2);
      wait_cycles($urandom_range(0, 25));
      busy_d = $urandom_range(1, 5);
      busy_l = $urandom_range(1, 20);
      if (pat < 2) begin
        raise_req(pat == 1, $urandom());
        await_ack(pat == 1);
        release_req(pat == 1);
      end else begin
        raise_both($urandom(), $urandom());
        fork
          begin await_ack(1'b0); release_req(1'b0); end
          begin await_ack(1'b1); release_req(1'b1); end
        join
      end
    end

    // Start timeouts with a dead UART, then saturation of err_count.
    wait_cycles(60);
    uart_dead = 1'b1;
    raise_req(1'b0, $urandom());
    await_ack(1'b0);
    release_req(1'b0);
    raise_req(1'b1, $urandom());
    await_ack(1'b1);
    release_req(1'b1);
    for (int n = 0; n < 300; n++) begin
      pat = $urandom_range(0, 1);
      raise_req(pat == 1, $urandom());
      await_ack(pat == 1);
      release_req(pat == 1);
    end
    wait_cycles(TO + G + 10);

    check("final_err_count", 64'(err_count), 64'd255);
    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_err_q_empty", 64'(err_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Last-resort bound on total run time.
  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
